// File: rtl/c17_eval_pkg.sv
// Shared definitions for the c17 benchmark evaluators: vector geometry, pin positions
// and the sweep FSM state type.
package c17_eval_pkg;

    localparam int unsigned C17_N_IN  = 5;
    localparam int unsigned C17_N_OUT = 2;
    localparam int unsigned C17_N_VEC = 32;

    localparam int unsigned IN_A_BIT  = 4;
    localparam int unsigned IN_B_BIT  = 3;
    localparam int unsigned IN_C_BIT  = 2;
    localparam int unsigned IN_D_BIT  = 1;
    localparam int unsigned IN_E_BIT  = 0;

    localparam int unsigned OUT_A_BIT = 1;
    localparam int unsigned OUT_B_BIT = 0;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } eval_state_e;

endpackage

// File: rtl/c17_golden.sv
// Combinational exact c17 reference: six 2-input NAND gates, 5 inputs, 2 outputs.
module c17_golden
    import c17_eval_pkg::*;
(
    input  logic [C17_N_IN-1:0]  in_i,
    output logic [C17_N_OUT-1:0] out_o
);

    logic a, b, c, d, e;
    logic n10, n11, n16, n19;

    assign a = in_i[IN_A_BIT];
    assign b = in_i[IN_B_BIT];
    assign c = in_i[IN_C_BIT];
    assign d = in_i[IN_D_BIT];
    assign e = in_i[IN_E_BIT];

    assign n10 = ~(a & c);
    assign n11 = ~(c & d);
    assign n16 = ~(b & n11);
    assign n19 = ~(n11 & e);

    always_comb begin
        out_o            = '0;
        out_o[OUT_A_BIT] = ~(n10 & n16);
        out_o[OUT_B_BIT] = ~(n16 & n19);
    end

endmodule

// File: rtl/c17_error_monitor.sv
// Sweeps all 32 c17 input vectors through a CUT, compares each settled response against
// the exact model and accumulates per-output and combined mismatch counts.
module c17_error_monitor
    import c17_eval_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [4:0]           cut_in,
    input  logic [1:0]           cut_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     err_a,
    output logic [CNT_W-1:0]     err_b,
    output logic [CNT_W-1:0]     err_any,
    output logic                 first_fail_valid,
    output logic [4:0]           first_fail_vec
);

    localparam logic [3:0]          SettleLoad = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]    CntMax     = '1;
    localparam logic [C17_N_IN-1:0] LastVec    = C17_N_IN'(C17_N_VEC - 1);

    eval_state_e         state_q;
    logic [3:0]          settle_q;
    logic [4:0]          cut_in_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    err_a_q;
    logic [CNT_W-1:0]    err_b_q;
    logic [CNT_W-1:0]    err_any_q;
    logic                ff_valid_q;
    logic [4:0]          ff_vec_q;

    logic [C17_N_OUT-1:0] gold;
    logic                 mis_a;
    logic                 mis_b;

    c17_golden u_golden (
        .in_i  (cut_in_q),
        .out_o (gold)
    );

    assign mis_a = cut_out[OUT_A_BIT] != gold[OUT_A_BIT];
    assign mis_b = cut_out[OUT_B_BIT] != gold[OUT_B_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            cut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_a_q    <= '0;
            err_b_q    <= '0;
            err_any_q  <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        cut_in_q   <= '0;
                        err_a_q    <= '0;
                        err_b_q    <= '0;
                        err_any_q  <= '0;
                        ff_valid_q <= 1'b0;
                        ff_vec_q   <= '0;
                        settle_q   <= SettleLoad;
                        busy_q     <= 1'b1;
                        state_q    <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_q == '0) begin
                        state_q <= StSample;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                StSample: begin
                    // Counters saturate so narrow builds never wrap back to a clean-looking value.
                    if (mis_a && err_a_q != CntMax) err_a_q <= err_a_q + CNT_W'(1);
                    if (mis_b && err_b_q != CntMax) err_b_q <= err_b_q + CNT_W'(1);
                    if ((mis_a || mis_b) && err_any_q != CntMax) begin
                        err_any_q <= err_any_q + CNT_W'(1);
                    end
                    if ((mis_a || mis_b) && !ff_valid_q) begin
                        ff_valid_q <= 1'b1;
                        ff_vec_q   <= cut_in_q;
                    end
                    if (cut_in_q == LastVec) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cut_in_q <= cut_in_q + 5'd1;
                        settle_q <= SettleLoad;
                        state_q  <= StSettle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cut_in           = cut_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_a            = err_a_q;
    assign err_b            = err_b_q;
    assign err_any          = err_any_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;

endmodule
